nios_ii_system_bcd_capture: RTL

Avalon-MM slave controller for the 12-bit BCD switch/thumbwheel input (3 digits) on the Nios II system bus. It synchronises and debounces the raw input and accepts a stable value. It then converts the 3-digit BCD value to binary with a sequential multiply-accumulate FSM and latches a change flag with a maskable interrupt. Software reads the debounced BCD value, the binary value and the status, and no longer polls the raw port.

---
 rtl/nios_ii_system_bcd_capture.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/nios_ii_system_bcd_capture.sv
// nios_ii_system_bcd_capture
//   Avalon-MM slave for a 3-digit BCD thumbwheel input. The raw port is
//   synchronised and debounced, and each newly accepted stable value is
//   converted to binary by a small multiply-accumulate FSM. A change flag
//   with a maskable interrupt is raised when a conversion completes.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 MASK, 2 STATUS, 3 DEBOUNCE)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, one cycle latency, updated every clock
//   in_port     raw BCD input {hundreds, tens, ones}
//   irq         registered change_flag & irq_mask
module nios_ii_system_bcd_capture #(
  parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [11:0] in_port,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D2     = 3'd1,
    D1     = 3'd2,
    D0     = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [11:0] sync_q1;
  logic [11:0] sync;
  logic [11:0] candidate;
  logic [15:0] counter;
  logic [15:0] reload;
  logic [11:0] stable;
  logic [9:0]  acc;
  logic [9:0]  binary;
  logic        digit_err;
  logic        change_flag;
  logic        irq_mask;

  logic        wr_en;
  logic        accept;
  logic        digit_bad;
  logic        busy;
  logic [3:0]  mac_digit;
  logic [9:0]  acc_x10;
  logic [9:0]  mac_sum;
  logic        unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign busy  = (state != IDLE);

  // Upper write bits have no register behind them.
  assign unused_wdata = ^writedata[31:16];

  // A settled candidate is only taken while the converter is idle; if the
  // converter is busy the candidate keeps its zero count and is taken later.
  assign accept = (sync == candidate) && (counter == '0) &&
                  (candidate != stable) && (state == IDLE);

  assign digit_bad = (stable[11:8] > 4'd9) || (stable[7:4] > 4'd9) ||
                     (stable[3:0] > 4'd9);

  // acc*10 as shift-and-add, truncated to the accumulator width.
  assign acc_x10   = {acc[6:0], 3'b000} + {acc[8:0], 1'b0};
  assign mac_digit = (state == D1) ? stable[7:4] : stable[3:0];
  assign mac_sum   = acc_x10 + {6'd0, mac_digit};

  // Input synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync    <= '0;
    end else begin
      sync_q1 <= in_port;
      sync    <= sync_q1;
    end
  end

  // Debouncer: any change of the synchronised value restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      counter   <= '0;
      stable    <= '0;
    end else if (sync != candidate) begin
      candidate <= sync;
      counter   <= reload;
    end else if (counter != '0) begin
      counter <= counter - 16'd1;
    end else if (accept) begin
      stable <= candidate;
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = D2;
      D2:      state_next = D1;
      D1:      state_next = D0;
      D0:      state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulator datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) acc <= '0;
        D2:      acc <= {6'd0, stable[11:8]};
        D1:      acc <= mac_sum;
        D0:      acc <= mac_sum;
        default: acc <= acc;
      endcase
    end
  end

  // Result registers; error digits discard the accumulated value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      binary    <= '0;
      digit_err <= 1'b0;
    end else if (state == COMMIT) begin
      binary    <= digit_bad ? '0 : acc;
      digit_err <= digit_bad;
    end
  end

  // Change flag: a completing conversion beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change_flag <= 1'b0;
    end else if (state == COMMIT) begin
      change_flag <= 1'b1;
    end else if (wr_en && (address == 2'd2) && writedata[0]) begin
      change_flag <= 1'b0;
    end
  end

  // Software-writable control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
      reload   <= DEBOUNCE_DEFAULT;
    end else if (wr_en) begin
      if (address == 2'd1) irq_mask <= writedata[0];
      if (address == 2'd3) reload   <= writedata[15:0];
    end
  end

  // Read mux, registered every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {digit_err, 5'd0, binary, 4'd0, stable};
        2'd1:    readdata <= {31'd0, irq_mask};
        2'd2:    readdata <= {30'd0, busy, change_flag};
        default: readdata <= {16'd0, reload};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= change_flag & irq_mask;
    end
  end

endmodule
